load_store_unit: RTL and testbench

- Memory stage of the RV32I core; sits directly downstream of the ALU.
- Takes the ALU effective address (ADD result of rs1 + imm) plus store data and funct3 from the EX stage.
- Runs a single-outstanding request/grant/response transaction on the data-memory port.
- Returns an aligned, sign- or zero-extended load result (or store completion) to write-back.

---
 rtl/load_store_unit_pkg.sv | 24 ++
 rtl/load_store_unit_if.sv | 24 ++
 rtl/load_store_unit_align.sv | 86 ++++++++
 rtl/load_store_unit.sv | 180 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared RV32I memory-stage definitions: funct3 codes, error codes and LSU states.
package rv32_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_ILLEGAL  = 2'd2,
        ERR_BUS      = 2'd3
    } lsu_err_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory port: single-outstanding request/grant plus read-data response.
interface load_store_unit_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  mem_req;
    logic                  mem_gnt;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [3:0]            mem_wstrb;
    logic                  mem_rvalid;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/load_store_unit_align.sv
// Combinational datapath of the LSU: accept-time legality checks, store lane
// replication/strobes, and load byte extraction with sign/zero extension.
module lsu_align
    import rv32_mem_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic        load_i,
    input  logic        store_i,
    input  logic [31:0] wdata_i,
    output lsu_err_e    err_o,
    output logic [31:0] st_wdata_o,
    output logic [3:0]  st_wstrb_o,
    input  logic [2:0]  ld_funct3_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] ld_data_o
);
    logic        illegal_s;
    logic        misalign_s;
    logic [31:0] sh_s;

    // Legality and alignment of the incoming op; illegal outranks misaligned.
    always_comb begin
        illegal_s  = 1'b0;
        misalign_s = 1'b0;
        if (load_i && store_i) begin
            illegal_s = 1'b1;
        end else if (load_i) begin
            case (funct3_i)
                F3_B, F3_H, F3_W, F3_BU, F3_HU: illegal_s = 1'b0;
                default:                        illegal_s = 1'b1;
            endcase
        end else if (store_i) begin
            case (funct3_i)
                F3_B, F3_H, F3_W: illegal_s = 1'b0;
                default:          illegal_s = 1'b1;
            endcase
        end else begin
            illegal_s = 1'b0;
        end
        case (funct3_i)
            F3_H, F3_HU: misalign_s = off_i[0];
            F3_W:        misalign_s = (off_i != 2'b00);
            default:     misalign_s = 1'b0;
        endcase
        if (illegal_s) begin
            err_o = ERR_ILLEGAL;
        end else if (misalign_s) begin
            err_o = ERR_MISALIGN;
        end else begin
            err_o = ERR_NONE;
        end
    end

    // Store data is replicated across lanes so the strobes alone pick the bytes.
    always_comb begin
        case (funct3_i)
            F3_B: begin
                st_wdata_o = {4{wdata_i[7:0]}};
                st_wstrb_o = 4'b0001 << off_i;
            end
            F3_H: begin
                st_wdata_o = {2{wdata_i[15:0]}};
                st_wstrb_o = 4'b0011 << off_i;
            end
            default: begin
                st_wdata_o = wdata_i;
                st_wstrb_o = 4'hF;
            end
        endcase
    end

    assign sh_s = rdata_i >> {ld_off_i, 3'b000};

    // Load extension uses the latched funct3/offset of the op in flight.
    always_comb begin
        case (ld_funct3_i)
            F3_B:    ld_data_o = {{24{sh_s[7]}}, sh_s[7:0]};
            F3_H:    ld_data_o = {{16{sh_s[15]}}, sh_s[15:0]};
            F3_BU:   ld_data_o = {24'd0, sh_s[7:0]};
            F3_HU:   ld_data_o = {16'd0, sh_s[15:0]};
            default: ld_data_o = sh_s;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// RV32I memory stage: accepts one load/store from EX, runs it on the data-memory
// port with a timeout, and returns a single-cycle write-back completion.
module load_store_unit
    import rv32_mem_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid_i,
    output logic                  ex_ready_o,
    input  logic                  ex_load_i,
    input  logic                  ex_store_i,
    input  logic [2:0]            ex_funct3_i,
    input  logic [ADDR_WIDTH-1:0] ex_addr_i,
    input  logic [DATA_WIDTH-1:0] ex_wdata_i,
    input  logic [4:0]            ex_rd_i,
    load_store_unit_if.master     mem,
    output logic                  wb_valid_o,
    output logic                  wb_we_o,
    output logic [4:0]            wb_rd_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    output logic [1:0]            wb_err_o
);
    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_e            state_q;
    logic [7:0]            cnt_q;
    logic                  ex_ready_q;
    logic                  is_load_q;
    logic [2:0]            funct3_q;
    logic [1:0]            off_q;
    logic                  mem_req_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic [3:0]            mem_wstrb_q;
    logic                  wb_valid_q;
    logic                  wb_we_q;
    logic [4:0]            wb_rd_q;
    logic [DATA_WIDTH-1:0] wb_data_q;
    lsu_err_e              wb_err_q;

    lsu_err_e              chk_err_s;
    logic [31:0]           st_wdata_s;
    logic [3:0]            st_wstrb_s;
    logic [31:0]           ld_data_s;
    logic                  accept_s;

    assign accept_s = ex_valid_i & ex_ready_q & (ex_load_i | ex_store_i);

    lsu_align u_align (
        .funct3_i    (ex_funct3_i),
        .off_i       (ex_addr_i[1:0]),
        .load_i      (ex_load_i),
        .store_i     (ex_store_i),
        .wdata_i     (ex_wdata_i),
        .err_o       (chk_err_s),
        .st_wdata_o  (st_wdata_s),
        .st_wstrb_o  (st_wstrb_s),
        .ld_funct3_i (funct3_q),
        .ld_off_i    (off_q),
        .rdata_i     (mem.mem_rdata),
        .ld_data_o   (ld_data_s)
    );

    // Transaction FSM with its timeout counter and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 8'd0;
            ex_ready_q  <= 1'b1;
            is_load_q   <= 1'b0;
            funct3_q    <= 3'd0;
            off_q       <= 2'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= 4'd0;
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= '0;
            wb_err_q    <= ERR_NONE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        ex_ready_q <= 1'b0;
                        is_load_q  <= ex_load_i;
                        funct3_q   <= ex_funct3_i;
                        off_q      <= ex_addr_i[1:0];
                        wb_rd_q    <= ex_rd_i;
                        wb_data_q  <= '0;
                        wb_err_q   <= chk_err_s;
                        if (chk_err_s != ERR_NONE) begin
                            state_q    <= RESP;
                            wb_valid_q <= 1'b1;
                            wb_we_q    <= 1'b0;
                        end else begin
                            state_q     <= REQ;
                            cnt_q       <= 8'd0;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= ex_store_i;
                            mem_addr_q  <= {ex_addr_i[ADDR_WIDTH-1:2], 2'b00};
                            mem_wdata_q <= ex_store_i ? st_wdata_s : 32'd0;
                            mem_wstrb_q <= ex_store_i ? st_wstrb_s : 4'd0;
                        end
                    end
                end
                REQ: begin
                    if (mem.mem_gnt) begin
                        mem_req_q <= 1'b0;
                        cnt_q     <= 8'd0;
                        if (is_load_q) begin
                            state_q <= WAIT;
                        end else begin
                            state_q    <= RESP;
                            wb_valid_q <= 1'b1;
                            wb_we_q    <= 1'b0;
                        end
                    end else if (cnt_q == TO_LIMIT) begin
                        mem_req_q  <= 1'b0;
                        state_q    <= RESP;
                        wb_valid_q <= 1'b1;
                        wb_we_q    <= 1'b0;
                        wb_err_q   <= ERR_BUS;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                WAIT: begin
                    // A response arriving on the limit cycle still completes normally.
                    if (mem.mem_rvalid) begin
                        wb_data_q  <= ld_data_s;
                        state_q    <= RESP;
                        wb_valid_q <= 1'b1;
                        wb_we_q    <= 1'b1;
                    end else if (cnt_q == TO_LIMIT) begin
                        wb_data_q  <= '0;
                        state_q    <= RESP;
                        wb_valid_q <= 1'b1;
                        wb_we_q    <= 1'b0;
                        wb_err_q   <= ERR_BUS;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                RESP: begin
                    wb_valid_q <= 1'b0;
                    wb_we_q    <= 1'b0;
                    ex_ready_q <= 1'b1;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q    <= IDLE;
                    mem_req_q  <= 1'b0;
                    wb_valid_q <= 1'b0;
                    wb_we_q    <= 1'b0;
                    ex_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign ex_ready_o    = ex_ready_q;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_wstrb = mem_wstrb_q;
    assign wb_valid_o    = wb_valid_q;
    assign wb_we_o       = wb_we_q;
    assign wb_rd_o       = wb_rd_q;
    assign wb_data_o     = wb_data_q;
    assign wb_err_o      = wb_err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: randomized ops against a byte-level
// reference model, with a memory responder and write-back monitor.
module tb_load_store_unit;
    localparam int TMO = 4;

    logic        clk;
    logic        rst_n;
    logic        ex_valid, ex_ready, ex_load, ex_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_wdata;
    logic [4:0]  ex_rd;
    logic        wb_valid, wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [1:0]  wb_err;

    load_store_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mif ();

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid_i(ex_valid), .ex_ready_o(ex_ready), .ex_load_i(ex_load),
        .ex_store_i(ex_store), .ex_funct3_i(ex_funct3), .ex_addr_i(ex_addr),
        .ex_wdata_i(ex_wdata), .ex_rd_i(ex_rd), .mem(mif),
        .wb_valid_o(wb_valid), .wb_we_o(wb_we), .wb_rd_o(wb_rd),
        .wb_data_o(wb_data), .wb_err_o(wb_err)
    );

    typedef struct {
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
        logic [1:0]  err;
        int          lat;
        int          acc;
    } wb_exp_t;

    wb_exp_t     exp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;

    // memory responder controls and the expected request of the op in flight
    int          gnt_delay = 0;
    int          rv_delay = 0;
    logic [31:0] rdata_v = 32'd0;
    bit          force_rvalid = 1'b0;
    bit          exp_req_valid = 1'b0;
    logic [31:0] exp_maddr, exp_mwdata;
    logic        exp_mwe;
    logic [3:0]  exp_mwstrb;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, expv, $time);
    endtask

    // Reference: byte-lane view of the op, plus latency from the responder delays.
    function automatic void model(input bit ld, input bit st, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] rdata, input int gd, input int rvd,
                                  input logic [4:0] rd, output wb_exp_t e,
                                  output logic [3:0] strb, output logic [31:0] lanes);
        int size, o;
        logic [31:0] mask, raw;
        bit illegal, mis;
        o    = int'(addr[1:0]);
        size = 1 << f3[1:0];
        illegal = (ld && st) || (ld && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}))
                  || (st && !(f3 inside {3'd0, 3'd1, 3'd2}));
        mis = (o % size) != 0;
        e.rd = rd; e.we = 1'b0; e.data = 32'd0; e.acc = 0;
        if (illegal) begin
            e.err = 2'd2; e.lat = 1;
        end else if (mis) begin
            e.err = 2'd1; e.lat = 1;
        end else if (gd >= TMO) begin
            e.err = 2'd3; e.lat = TMO + 1;
        end else if (ld && rvd >= TMO) begin
            e.err = 2'd3; e.lat = gd + 2 + TMO;
        end else begin
            e.err = 2'd0;
            if (st) begin
                e.lat = gd + 2;
            end else begin
                e.lat = gd + 3 + rvd;
                e.we  = 1'b1;
                mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
                raw  = (rdata >> (8 * o)) & mask;
                if (!f3[2] && size < 4 && raw[8 * size - 1]) raw = raw | ~mask;
                e.data = raw;
            end
        end
        strb  = 4'd0;
        lanes = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if (i >= o && i < o + size) strb[i] = 1'b1;
            lanes[8 * i +: 8] = wdata[8 * (i % size) +: 8];
        end
    endfunction

    // Memory responder and write-back monitor, decoupled from stimulus.
    initial begin : bus
        int req_cnt;
        int wait_cnt;
        wb_exp_t e;
        req_cnt = 0;
        wait_cnt = -1;
        mif.mem_gnt = 1'b0;
        mif.mem_rvalid = 1'b0;
        mif.mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            mif.mem_gnt    = 1'b0;
            mif.mem_rvalid = force_rvalid;
            mif.mem_rdata  = $urandom;
            if (!rst_n) begin
                req_cnt = 0;
                wait_cnt = -1;
            end else begin
                if (wb_valid) begin
                    chk("wb_expected", 32'(exp_q.size() != 0), 32'd1);
                    chk("req_low_at_wb", 32'(mif.mem_req), 32'd0);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                        chk("wb_we", 32'(wb_we), 32'(e.we));
                        chk("wb_data", wb_data, e.data);
                        chk("wb_err", 32'(wb_err), 32'(e.err));
                        chk("latency", 32'(cyc - e.acc), 32'(e.lat));
                    end
                    exp_req_valid = 1'b0;
                    wait_cnt = -1;
                end
                if (wait_cnt >= 0) begin
                    if (wait_cnt == rv_delay) begin
                        mif.mem_rvalid = 1'b1;
                        mif.mem_rdata  = rdata_v;
                        wait_cnt = -1;
                    end else begin
                        wait_cnt++;
                    end
                end
                if (mif.mem_req) begin
                    chk("req_expected", 32'(exp_req_valid), 32'd1);
                    if (req_cnt == gnt_delay) begin
                        mif.mem_gnt = 1'b1;
                        chk("mem_addr", mif.mem_addr, exp_maddr);
                        chk("mem_we", 32'(mif.mem_we), 32'(exp_mwe));
                        chk("mem_wstrb", 32'(mif.mem_wstrb), 32'(exp_mwstrb));
                        if (exp_mwe) chk("mem_wdata", mif.mem_wdata, exp_mwdata);
                        if (!mif.mem_we) wait_cnt = 0;
                        exp_req_valid = 1'b0;
                    end
                    req_cnt++;
                end else begin
                    req_cnt = 0;
                end
            end
        end
    end

    task automatic issue(input bit ld, input bit st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int gd, input int rvd);
        wb_exp_t e;
        logic [3:0] strb;
        logic [31:0] lanes;
        logic [4:0] rd;
        int n;
        n = 0;
        while (ex_ready !== 1'b1 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        chk("ready_wait", 32'(ex_ready), 32'd1);
        rd = 5'($urandom);
        model(ld, st, f3, addr, wdata, rdata, gd, rvd, rd, e, strb, lanes);
        gnt_delay = gd;
        rv_delay  = rvd;
        rdata_v   = rdata;
        if (ld || st) begin
            e.acc = cyc;
            exp_q.push_back(e);
            if (e.err == 2'd0 || e.err == 2'd3) begin
                exp_req_valid = 1'b1;
                exp_maddr  = addr & 32'hFFFF_FFFC;
                exp_mwe    = st;
                exp_mwstrb = st ? strb : 4'd0;
                exp_mwdata = lanes;
            end
        end
        ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_funct3 = f3;
        ex_addr = addr; ex_wdata = wdata; ex_rd = rd;
        @(negedge clk); #1;
        ex_valid = 1'b0; ex_load = 1'($urandom); ex_store = 1'($urandom);
        ex_addr = $urandom; ex_wdata = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk); #1;
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin : stim
        logic [2:0] lf [5];
        int r;
        bit ld, st;
        logic [2:0] f3;
        logic [31:0] addr;
        lf = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        rst_n = 1'b0; ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
        ex_funct3 = 3'd0; ex_addr = 32'd0; ex_wdata = 32'd0; ex_rd = 5'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ex_ready", 32'(ex_ready), 32'd1);
        chk("rst_mem_req", 32'(mif.mem_req), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wstrb", 32'(mif.mem_wstrb), 32'd0);
        chk("rst_wb_err", 32'(wb_err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk); #1;

        issue(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 32'd0, 0, 0);
        issue(1'b1, 1'b0, 3'b000, 32'h0000_2002, 32'd0, 32'h12F0_3456, 0, 0);
        issue(1'b1, 1'b0, 3'b100, 32'h0000_2002, 32'd0, 32'h12F0_3456, 0, 0);
        issue(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'd0, 32'h12F0_3456, 0, 0);
        issue(1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'd0, 32'd0, 0, 0);
        issue(1'b0, 1'b1, 3'b001, 32'h0000_3003, 32'h1234_5678, 32'd0, 0, 0);
        issue(1'b1, 1'b0, 3'b011, 32'h0000_3000, 32'd0, 32'd0, 0, 0);
        issue(1'b1, 1'b1, 3'b010, 32'h0000_3000, 32'd0, 32'd0, 0, 0);
        issue(1'b0, 1'b1, 3'b100, 32'h0000_3000, 32'd0, 32'd0, 0, 0);
        issue(1'b1, 1'b0, 3'b010, 32'h0000_3100, 32'd0, 32'hDEAD_BEEF, 1000, 0);
        issue(1'b1, 1'b0, 3'b010, 32'h0000_3104, 32'd0, 32'hCAFE_F00D, 3, 0);
        issue(1'b1, 1'b0, 3'b001, 32'h0000_3106, 32'd0, 32'h8001_0000, 0, 1000);
        issue(1'b1, 1'b0, 3'b101, 32'h0000_3106, 32'd0, 32'h8001_0000, 0, 3);
        drain();
        issue(1'b0, 1'b0, 3'b010, 32'h0000_3000, 32'd0, 32'd0, 0, 0);
        chk("ignored_ready", 32'(ex_ready), 32'd1);

        // abort a load while it waits for read data
        issue(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'd0, 32'h1111_2222, 0, 1000);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("abort_mem_req", 32'(mif.mem_req), 32'd0);
        chk("abort_ex_ready", 32'(ex_ready), 32'd1);
        exp_q.delete();
        exp_req_valid = 1'b0;
        @(negedge clk); #2;
        rst_n = 1'b1;
        force_rvalid = 1'b1;
        @(negedge clk); #2;
        force_rvalid = 1'b0;
        chk("stray_no_wb0", 32'(wb_valid), 32'd0);
        @(negedge clk); #1;
        chk("stray_no_wb1", 32'(wb_valid), 32'd0);
        issue(1'b1, 1'b0, 3'b010, 32'h0000_4000, 32'd0, 32'h0BAD_F00D, 0, 0);
        drain();

        for (int k = 0; k < 200; k++) begin
            r  = $urandom_range(0, 19);
            ld = (r < 9) || (r == 18);
            st = (r >= 9 && r < 19);
            if ($urandom_range(0, 3) == 0) f3 = 3'($urandom);
            else if (ld) f3 = lf[$urandom_range(0, 4)];
            else f3 = 3'($urandom_range(0, 2));
            addr = $urandom;
            if ($urandom_range(0, 2) != 0) begin
                if (f3[1:0] == 2'd2) addr[1:0] = 2'd0;
                else if (f3[1:0] == 2'd1) addr[0] = 1'b0;
            end
            issue(ld, st, f3, addr, $urandom, $urandom,
                  $urandom_range(0, 5), $urandom_range(0, 5));
        end
        drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
